// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS-32 control path: opcodes, FSM states,
// and the alu_op / alu_src_b / pc_source select codes. The ALU-control decoder
// imports the same alu_op constants so the producer and consumer cannot drift.
package mips_multicycle_control_pkg;

  // instruction[31:26] values handled by the control FSM
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Codes 12-15 are unused; the FSM treats them as a return to FETCH.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  // alu_op codes; 2'b11 is reserved and never driven
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALU_B_REG     = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  function automatic logic is_supported_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: is_supported_op = 1'b1;
      default:                                       is_supported_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS-32 datapath.
// Latency: R-type 4, lw 5, sw 4, addi 4, beq 3, j 3 cycles, plus one per memory wait cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold their memory strobes until mem_ready; elsewhere mem_ready is ignored.
// Ports: clk, rst_n (sync, active-low); opcode, mem_ready in; datapath strobes and
//   selects (pc_write .. pc_source) out; instr_done / illegal_op pulses; state for debug.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  // Must be a legal state encoding; an out-of-range value falls back to FETCH one edge later.
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= state_t'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  // next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      // only lw and sw reach MEMADR
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode. Everything is gated by rst_n so no strobe escapes in a
  // reset cycle, even when the register still holds a mid-instruction state.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_B_REG;
    alu_op        = ALU_OP_ADD;
    pc_source     = PC_SRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ALU_B_FOUR;
          alu_op    = ALU_OP_ADD;
          // IR and PC load only in the cycle memory delivers the instruction
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = ALU_B_IMM_SH2;
          alu_op     = ALU_OP_ADD;
          illegal_op = ~is_supported_op(opcode);
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = ALU_B_IMM;
          alu_op    = ALU_OP_ADD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_FUNCT;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_OP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PC_SRC_ALUOUT;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PC_SRC_JUMP;
          instr_done = 1'b1;
        end
        default: begin
          pc_write = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Table-driven bench for mips_multicycle_control: per-cycle vectors of
// {rst_n, opcode, mem_ready, expected state, expected outputs}, a scoreboard
// queue of expectations, plus hand sequences for stalls, reset and latency.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [3:0] st;
    ctl_t       ctl;
  } vec_t;

  // Expected output bundles, written straight from the per-state output list.
  localparam ctl_t C_ZERO    = '{default: '0};
  localparam ctl_t C_FETCH_W = '{mem_read: 1'b1, alu_src_b: 2'b01, default: '0};
  localparam ctl_t C_FETCH_R = '{mem_read: 1'b1, alu_src_b: 2'b01, ir_write: 1'b1, pc_write: 1'b1, default: '0};
  localparam ctl_t C_DECODE  = '{alu_src_b: 2'b11, default: '0};
  localparam ctl_t C_DEC_ILL = '{alu_src_b: 2'b11, illegal_op: 1'b1, default: '0};
  localparam ctl_t C_ADDR    = '{alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
  localparam ctl_t C_MEMRD   = '{mem_read: 1'b1, iord: 1'b1, default: '0};
  localparam ctl_t C_MEMWB   = '{reg_write: 1'b1, mem_to_reg: 1'b1, instr_done: 1'b1, default: '0};
  localparam ctl_t C_MEMWR_W = '{mem_write: 1'b1, iord: 1'b1, default: '0};
  localparam ctl_t C_MEMWR_R = '{mem_write: 1'b1, iord: 1'b1, instr_done: 1'b1, default: '0};
  localparam ctl_t C_EXEC    = '{alu_src_a: 1'b1, alu_op: 2'b10, default: '0};
  localparam ctl_t C_ALUWB   = '{reg_write: 1'b1, reg_dst: 1'b1, instr_done: 1'b1, default: '0};
  localparam ctl_t C_ADDIWB  = '{reg_write: 1'b1, instr_done: 1'b1, default: '0};
  localparam ctl_t C_BRANCH  = '{alu_src_a: 1'b1, alu_op: 2'b01, pc_write_cond: 1'b1, pc_source: 2'b01, instr_done: 1'b1, default: '0};
  localparam ctl_t C_JUMP    = '{pc_write: 1'b1, pc_source: 2'b10, instr_done: 1'b1, default: '0};

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, AI = 6'b001000, BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  ctl_t       act;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  assign act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, instr_done, illegal_op};

  int   pass_cnt = 0;
  int   total    = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, got, want);
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic mr, input logic [3:0] st, input ctl_t c);
    vec_t v;
    v.rst_n = r; v.opcode = op; v.mem_ready = mr; v.st = st; v.ctl = c;
    tbl.push_back(v);
  endtask

  // Drive one cycle's inputs on the falling edge, queue the expectation,
  // then compare once the combinational outputs have settled.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst_n = v.rst_n; opcode = v.opcode; mem_ready = v.mem_ready;
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    check("state", idx, {28'd0, state}, {28'd0, e.st});
    check("ctl", idx, {14'd0, act}, {14'd0, e.ctl});
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic mr, input logic [3:0] st, input ctl_t c, input int idx);
    vec_t v;
    v.rst_n = r; v.opcode = op; v.mem_ready = mr; v.st = st; v.ctl = c;
    apply(v, idx);
  endtask

  // Cycles from FETCH through the instr_done cycle with mem_ready held high.
  task automatic latency(input logic [5:0] op, input int want, input int idx);
    int n;
    logic seen;
    n = 0; seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; opcode = op; mem_ready = 1'b1;
    #2;
    check("lat_start_state", idx, {28'd0, state}, 32'd0);
    while (!seen && n < 20) begin
      n++;
      if (instr_done) seen = 1'b1;
      else begin
        @(negedge clk);
        #2;
      end
    end
    if (!seen) n = -1;
    check("latency", idx, n, want);
  endtask

  initial begin
    rst_n = 1'b0; opcode = RT; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    add(0, RT, 1, 0, C_ZERO);
    add(1, RT, 1, 0, C_FETCH_R);
    add(1, RT, 1, 1, C_DECODE);
    add(1, RT, 1, 6, C_EXEC);
    add(1, RT, 0, 7, C_ALUWB);
    // lw with two wait cycles in MEMRD
    add(1, LW, 0, 0, C_FETCH_W);
    add(1, LW, 1, 0, C_FETCH_R);
    add(1, LW, 1, 1, C_DECODE);
    add(1, LW, 1, 2, C_ADDR);
    add(1, LW, 0, 3, C_MEMRD);
    add(1, LW, 0, 3, C_MEMRD);
    add(1, LW, 1, 3, C_MEMRD);
    add(1, LW, 0, 4, C_MEMWB);
    // sw with one wait cycle
    add(1, SW, 1, 0, C_FETCH_R);
    add(1, SW, 1, 1, C_DECODE);
    add(1, SW, 1, 2, C_ADDR);
    add(1, SW, 0, 5, C_MEMWR_W);
    add(1, SW, 1, 5, C_MEMWR_R);
    // beq, j (mem_ready low is ignored there)
    add(1, BQ, 1, 0, C_FETCH_R);
    add(1, BQ, 0, 1, C_DECODE);
    add(1, BQ, 0, 8, C_BRANCH);
    add(1, JP, 1, 0, C_FETCH_R);
    add(1, JP, 1, 1, C_DECODE);
    add(1, JP, 0, 9, C_JUMP);
    // addi
    add(1, AI, 1, 0, C_FETCH_R);
    add(1, AI, 1, 1, C_DECODE);
    add(1, AI, 1, 10, C_ADDR);
    add(1, AI, 1, 11, C_ADDIWB);
    // illegal opcode: one-cycle pulse, back to FETCH
    add(1, BAD, 1, 0, C_FETCH_R);
    add(1, BAD, 1, 1, C_DEC_ILL);
    add(1, SW, 0, 0, C_FETCH_W);
    // reset during a pending sw: no write strobe, FETCH on the next edge
    add(1, SW, 1, 0, C_FETCH_R);
    add(1, SW, 1, 1, C_DECODE);
    add(1, SW, 0, 2, C_ADDR);
    add(1, SW, 0, 5, C_MEMWR_W);
    add(0, SW, 0, 5, C_ZERO);
    add(0, SW, 1, 0, C_ZERO);
    add(1, SW, 0, 0, C_FETCH_W);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // FETCH stall of random length: request held, no IR/PC load
    begin
      int n;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) step(1, LW, 0, 0, C_FETCH_W, 100 + k);
    end
    // reset while a lw read is still pending
    step(1, LW, 1, 0, C_FETCH_R, 110);
    step(1, LW, 1, 1, C_DECODE, 111);
    step(1, LW, 1, 2, C_ADDR, 112);
    step(1, LW, 0, 3, C_MEMRD, 113);
    step(0, LW, 0, 3, C_ZERO, 114);
    step(1, LW, 0, 0, C_FETCH_W, 115);

    latency(RT, 4, 200);
    latency(LW, 5, 201);
    latency(SW, 4, 202);
    latency(AI, 4, 203);
    latency(BQ, 3, 204);
    latency(JP, 3, 205);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
